frac_linebuf_prefetch: RTL and testbench

//  Parametrised line-buffer prefetch controller between frac_disp and frame_buf. Replaces the

---
 rtl/frac_linebuf_prefetch_pkg.sv | 20 ++
 rtl/frac_linebuf_prefetch_pattern_chk.sv | 32 +++
 rtl/frac_linebuf_prefetch.sv | 149 ++++++++++++++
 tb/tb_frac_linebuf_prefetch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_linebuf_prefetch_pkg.sv
// Shared types for the line-buffer prefetch controller: FSM state encoding
// and bank-index width helper.
package frac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT_FILL,
        DRAIN
    } pf_state_t;

    function automatic int unsigned bank_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bank index width for the default two-bank ring.
    localparam int unsigned BANK_W = bank_width(2);

endpackage

// File: rtl/frac_linebuf_prefetch_pattern_chk.sv
// Pixel pattern checker: each consumed word must equal its zero-extended row
// index; mismatches set a sticky flag and bump a saturating counter.
module frac_pattern_chk #(
    parameter int ROW_W  = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic [ROW_W-1:0]  pix_row,
    input  logic [DATA_W-1:0] pix_data,
    output logic              diag_err,
    output logic [15:0]       err_count
);

    logic mismatch;

    assign mismatch = pix_valid && (pix_data != DATA_W'(pix_row));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diag_err  <= 1'b0;
            err_count <= '0;
        end else if (mismatch) begin
            diag_err <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/frac_linebuf_prefetch.sv
// N-bank ring line-buffer prefetch controller: issues DDR2 row reads ahead of
// the display, tracks bank occupancy and flags display underrun.
module frac_linebuf_prefetch
    import frac_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int ROW_W     = 13,
    parameter int LINES     = 768,
    parameter int DATA_W    = 16,
    parameter bit CHECK_EN  = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                frame_start,
    input  logic                                line_done,
    output logic                                req_rd_ddr,
    output logic [ROW_W-1:0]                    req_ddr_addr_row,
    output logic [bank_width(NUM_BANKS)-1:0]    req_bank,
    input  logic                                req_ack,
    input  logic                                fill_done,
    output logic [NUM_BANKS-1:0]                bank_valid,
    output logic [bank_width(NUM_BANKS)-1:0]    rd_bank,
    output logic                                underrun,
    input  logic                                pix_valid,
    input  logic [ROW_W-1:0]                    pix_row,
    input  logic [DATA_W-1:0]                   pix_data,
    output logic                                diag_err,
    output logic [15:0]                         err_count
);

    localparam int BW = int'(bank_width(NUM_BANKS));
    localparam logic [ROW_W:0] LAST_ROW = (ROW_W + 1)'(LINES);

    pf_state_t            state, state_next;
    logic [ROW_W:0]       wr_row;
    logic [BW-1:0]        wr_bank;
    logic                 req_next;
    logic                 clear_all;
    logic                 fill_accept;
    logic                 consume;
    logic                 starve;
    logic [NUM_BANKS-1:0] bv_next;

    assign req_ddr_addr_row = wr_row[ROW_W-1:0];
    assign req_bank         = wr_bank;
    assign consume          = line_done &&  bank_valid[rd_bank];
    assign starve           = line_done && !bank_valid[rd_bank];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_next    = 1'b0;
        clear_all   = 1'b0;
        fill_accept = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_next = CLEAR;
            end
            CLEAR: begin
                clear_all  = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                // An ack in the same cycle as frame_start means a fill is already in flight.
                if (frame_start) begin
                    state_next = (req_rd_ddr && req_ack) ? DRAIN : CLEAR;
                end else if (req_rd_ddr) begin
                    if (req_ack) state_next = WAIT_FILL;
                    else         req_next   = 1'b1;
                end else if (wr_row == LAST_ROW) begin
                    state_next = IDLE;
                end else begin
                    req_next = !bank_valid[wr_bank];
                end
            end
            WAIT_FILL: begin
                if (frame_start) begin
                    state_next = fill_done ? CLEAR : DRAIN;
                end else if (fill_done) begin
                    fill_accept = 1'b1;
                    state_next  = ISSUE;
                end
            end
            DRAIN: begin
                if (fill_done) state_next = CLEAR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bv_next = bank_valid;
        if (fill_accept) bv_next[wr_bank] = 1'b1;
        if (consume)     bv_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_rd_ddr <= 1'b0;
            wr_row     <= '0;
            wr_bank    <= '0;
            rd_bank    <= '0;
            bank_valid <= '0;
            underrun   <= 1'b0;
        end else begin
            req_rd_ddr <= req_next;
            if (starve) underrun <= 1'b1;
            if (clear_all) begin
                bank_valid <= '0;
                wr_row     <= '0;
                wr_bank    <= '0;
                rd_bank    <= '0;
            end else begin
                bank_valid <= bv_next;
                if (fill_accept) begin
                    wr_row  <= wr_row + (ROW_W + 1)'(1);
                    wr_bank <= wr_bank + BW'(1);
                end
                if (consume) rd_bank <= rd_bank + BW'(1);
            end
        end
    end

    if (CHECK_EN) begin : g_chk
        frac_pattern_chk #(
            .ROW_W  (ROW_W),
            .DATA_W (DATA_W)
        ) u_chk (
            .clk       (clk),
            .rst_n     (rst_n),
            .pix_valid (pix_valid),
            .pix_row   (pix_row),
            .pix_data  (pix_data),
            .diag_err  (diag_err),
            .err_count (err_count)
        );
    end else begin : g_nochk
        assign diag_err  = 1'b0;
        assign err_count = '0;
    end

endmodule

// File: tb/tb_frac_linebuf_prefetch.sv
// Randomised bench for frac_linebuf_prefetch: a frame_buf responder plus a
// row/consume-count model of the bank ring and the pattern checker.
module tb_frac_linebuf_prefetch;

    localparam int NB = 4;
    localparam int RW = 13;
    localparam int LN = 8;
    localparam int DW = 16;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          line_done = 1'b0;
    logic          req_ack = 1'b0;
    logic          fill_done = 1'b0;
    logic          pix_valid = 1'b0;
    logic [RW-1:0] pix_row = '0;
    logic [DW-1:0] pix_data = '0;
    logic          req_rd_ddr;
    logic [RW-1:0] req_ddr_addr_row;
    logic [BW-1:0] req_bank;
    logic [NB-1:0] bank_valid;
    logic [BW-1:0] rd_bank;
    logic          underrun;
    logic          diag_err;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    frac_linebuf_prefetch #(
        .NUM_BANKS (NB),
        .ROW_W     (RW),
        .LINES     (LN),
        .DATA_W    (DW),
        .CHECK_EN  (1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .line_done        (line_done),
        .req_rd_ddr       (req_rd_ddr),
        .req_ddr_addr_row (req_ddr_addr_row),
        .req_bank         (req_bank),
        .req_ack          (req_ack),
        .fill_done        (fill_done),
        .bank_valid       (bank_valid),
        .rd_bank          (rd_bank),
        .underrun         (underrun),
        .pix_valid        (pix_valid),
        .pix_row          (pix_row),
        .pix_data         (pix_data),
        .diag_err         (diag_err),
        .err_count        (err_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: rows filled and lines consumed in the current frame.
    int fetched = 0;
    int consumed = 0;
    int m_errs = 0;
    bit m_underrun = 1'b0;
    bit m_diag = 1'b0;
    bit m_active = 1'b0;
    bit settling = 1'b0;

    // frame_buf responder state: 0 idle, 1 request seen, 2 fill pending.
    int r_state = 0;
    int r_cnt = 0;
    int acked_row = -1;
    int no_req = 0;
    int settle_cnt = 0;
    int drain_row = -1;
    bit stale = 1'b0;
    bit just_acked = 1'b0;
    logic fill_is_stale = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] exp_bv();
        logic [NB-1:0] v;
        v = '0;
        for (int r = consumed; r < fetched; r++) v[r % NB] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        logic          ld, fd, fds, fs, pv;
        logic [RW-1:0] pr;
        logic [DW-1:0] pd;
        ld = line_done; fd = fill_done; fds = fill_is_stale; fs = frame_start;
        pv = pix_valid; pr = pix_row; pd = pix_data;
        @(posedge clk);
        #1;
        if (fs) begin
            fetched = 0; consumed = 0; settling = 1'b1; settle_cnt = 0; m_active = 1'b1;
        end else begin
            if (ld) begin
                if (consumed < fetched) consumed++;
                else m_underrun = 1'b1;
            end
            if (fd && !fds) fetched++;
        end
        if (pv && (pd !== {{(DW-RW){1'b0}}, pr})) begin
            m_diag = 1'b1;
            if (m_errs < 65535) m_errs++;
        end
        line_done = 1'b0; fill_done = 1'b0; fill_is_stale = 1'b0;
        frame_start = 1'b0; req_ack = 1'b0; pix_valid = 1'b0;
    endtask

    task automatic cycle(input bit ld_en, input bit rand_fs);
        bit quiet;
        tick();
        chk("underrun", underrun, m_underrun);
        chk("diag_err", diag_err, m_diag);
        chk("err_count", err_count, m_errs);
        if (just_acked) begin
            chk("req_drop_after_ack", req_rd_ddr, 0);
            just_acked = 1'b0;
        end else if (req_rd_ddr) begin
            if (r_state == 0) begin
                settling = 1'b0; settle_cnt = 0; no_req = 0;
                chk("req_row", req_ddr_addr_row, fetched);
                chk("req_bank", req_bank, fetched % NB);
                chk("req_legal", m_active && (fetched - consumed < NB) && (fetched < LN), 1);
                chk("req_not_draining", stale, 0);
                r_state = 1;
                r_cnt = $urandom_range(0, 3);
            end else if (r_state == 1) begin
                chk("req_row_hold", req_ddr_addr_row, fetched);
            end else begin
                chk("req_during_fill", req_rd_ddr, 0);
            end
        end else if (r_state == 1) begin
            chk("req_held", req_rd_ddr, 1);
            r_state = 0;
        end
        if (!settling) begin
            chk("bank_valid", bank_valid, exp_bv());
            chk("rd_bank", rd_bank, consumed % NB);
        end else begin
            settle_cnt++;
            if (settle_cnt > 40) begin
                chk("settle_timeout", req_rd_ddr, 1);
                settling = 1'b0;
            end
        end
        if (m_active && !settling && r_state == 0 && !stale && !req_rd_ddr &&
            (fetched - consumed < NB) && (fetched < LN)) begin
            no_req++;
            if (no_req > 4) begin
                chk("req_timeout", req_rd_ddr, 1);
                no_req = 0;
            end
        end else begin
            no_req = 0;
        end

        case (r_state)
            1: begin
                if (r_cnt == 0) begin
                    req_ack = 1'b1; r_state = 2; just_acked = 1'b1;
                    acked_row = fetched; r_cnt = $urandom_range(1, 12);
                end else begin
                    r_cnt--;
                end
            end
            2: begin
                if (r_cnt == 0) begin
                    fill_done = 1'b1; fill_is_stale = stale; stale = 1'b0; r_state = 0;
                end else begin
                    r_cnt--;
                end
            end
            default: ;
        endcase
        if (ld_en && !settling && consumed < fetched && $urandom_range(0, 2) == 0)
            line_done = 1'b1;
        quiet = !req_ack && !fill_done && !line_done;
        if (quiet && m_active && !settling && r_state == 2 && !stale && !just_acked &&
            drain_row >= 0 && acked_row == drain_row) begin
            frame_start = 1'b1; drain_row = -1;
        end else if (quiet && rand_fs && m_active && !settling && consumed < LN &&
                     $urandom_range(0, 149) == 0) begin
            frame_start = 1'b1;
        end
        if (frame_start) begin
            if (r_state == 1) r_state = 0;
            if (r_state == 2) stale = 1'b1;
            no_req = 0;
        end
        pix_valid = 1'($urandom_range(0, 1));
        pix_row = RW'($urandom);
        pix_data = ($urandom_range(0, 3) == 0) ? DW'($urandom) : {{(DW-RW){1'b0}}, pix_row};
    endtask

    task automatic run_frame(input bit rand_fs);
        for (int g = 0; g < 3000 && consumed < LN; g++) cycle(1'b1, rand_fs);
        if (consumed < LN) chk("frame_timeout", consumed, LN);
    endtask

    task automatic start_frame(input bit ld_en);
        frame_start = 1'b1;
        cycle(ld_en, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", req_rd_ddr, 0);
        chk("rst_row", req_ddr_addr_row, 0);
        chk("rst_bank", req_bank, 0);
        chk("rst_bank_valid", bank_valid, 0);
        chk("rst_rd_bank", rd_bank, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_diag", diag_err, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pattern checker: matching word, then one with a stray high bit.
        pix_valid = 1'b1; pix_row = 13'h0A5; pix_data = 16'h00A5;
        tick();
        chk("chk_match_diag", diag_err, 0);
        chk("chk_match_cnt", err_count, 0);
        pix_valid = 1'b1; pix_row = 13'h0A5; pix_data = 16'h10A5;
        tick();
        chk("chk_mismatch_diag", diag_err, 1);
        chk("chk_mismatch_cnt", err_count, 1);

        // No requests before the first frame_start.
        repeat (10) cycle(1'b0, 1'b0);

        // Display stalled: ring fills, then the controller waits.
        start_frame(1'b0);
        repeat (150) cycle(1'b0, 1'b0);
        chk("stall_bank_valid", bank_valid, 4'hF);
        chk("stall_no_req", req_rd_ddr, 0);

        // Resume display: remaining rows stream through, then idle.
        run_frame(1'b0);
        repeat (15) cycle(1'b1, 1'b0);
        chk("frame_end_underrun", underrun, 0);

        // Restart while row 5 is being filled.
        drain_row = 5;
        start_frame(1'b1);
        run_frame(1'b0);
        chk("drain_no_underrun", underrun, 0);

        // Frames with random mid-frame restarts.
        for (int f = 0; f < 3; f++) begin
            start_frame(1'b1);
            run_frame(1'b1);
        end
        repeat (10) cycle(1'b1, 1'b0);

        // Starved display: line_done before anything was filled.
        start_frame(1'b0);
        line_done = 1'b1;
        cycle(1'b0, 1'b0);
        chk("starve_underrun", underrun, 1);
        chk("starve_rd_bank", rd_bank, 0);
        start_frame(1'b1);
        repeat (10) cycle(1'b1, 1'b0);
        chk("underrun_sticky", underrun, 1);

        // Asynchronous reset while a request is outstanding.
        for (int i = 0; i < 200 && !req_rd_ddr; i++) cycle(1'b1, 1'b0);
        chk("mid_req_seen", req_rd_ddr, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req", req_rd_ddr, 0);
        chk("arst_row", req_ddr_addr_row, 0);
        chk("arst_bank", req_bank, 0);
        chk("arst_bank_valid", bank_valid, 0);
        chk("arst_rd_bank", rd_bank, 0);
        chk("arst_underrun", underrun, 0);
        chk("arst_diag", diag_err, 0);
        chk("arst_err_count", err_count, 0);
        fetched = 0; consumed = 0; m_errs = 0; m_underrun = 1'b0; m_diag = 1'b0;
        m_active = 1'b0; settling = 1'b0; r_state = 0; stale = 1'b0; just_acked = 1'b0;
        no_req = 0;
        line_done = 1'b0; fill_done = 1'b0; fill_is_stale = 1'b0;
        frame_start = 1'b0; req_ack = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0);
            chk("post_rst_no_req", req_rd_ddr, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
